apb3_master: RTL and testbench
==============================

APB3_MASTER -- requirements
Module: apb3_master

Interface
REQ-001 Parameter N_BIT_DATA, default 32, SHALL set the width of the data buses (PWDATA, PRDATA, req_wdata, resp_rdata).
REQ-002 Parameter N_BIT_ADDRESS, default 4, SHALL set the width of the address buses (PADDR, req_address).
REQ-003 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum ACCESS cycles with PREADY low before abort; a value of 0 SHALL disable the timeout.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  synchronous active-high reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when high together with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_address  in  N_BIT_ADDRESS  target address.
- req_wdata  in  N_BIT_DATA  write data.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumed.
- resp_rdata  out  N_BIT_DATA  read data; 0 for writes and timeouts.
- resp_error  out  1  PSLVERR was high or the access timed out.
- PSEL, PENABLE, PWRITE  out  1 each  APB3 control.
- PADDR  out  N_BIT_ADDRESS  APB address.
- PWDATA  out  N_BIT_DATA  APB write data.
- PRDATA  in  N_BIT_DATA  APB read data.
- PREADY, PSLVERR  in  1 each  APB3 slave status.

Function
REQ-005 The block SHALL implement an FSM with states IDLE, SETUP, ACCESS and RESPONSE, and SHALL have at most one transfer outstanding.
REQ-006 In IDLE, req_ready SHALL be 1 and PSEL = PENABLE = resp_valid = 0.
- On req_valid = 1 at an edge, the block SHALL capture req_write/req_address/req_wdata and go to SETUP.
REQ-007 req_ready SHALL be 0 in every state other than IDLE, and req_* SHALL be ignored there.
REQ-008 In SETUP, PSEL SHALL be 1 and PENABLE 0, with PADDR/PWRITE/PWDATA driven from the captured command; the next state SHALL be ACCESS unconditionally.
REQ-009 In ACCESS, PSEL and PENABLE SHALL be 1, and PADDR/PWRITE/PWDATA SHALL be held identical to their SETUP values.
REQ-010 In ACCESS, if PREADY === 1 at an edge, the block SHALL:
- latch resp_error = (PSLVERR === 1);
- latch resp_rdata = PRDATA for reads, or 0 for writes;
- go to RESPONSE.
REQ-011 PREADY values of 0, X or Z SHALL count as not ready; PRDATA and PSLVERR SHALL be sampled only under REQ-010.
REQ-012 A wait counter SHALL clear on entering ACCESS and increment on each ACCESS edge with PREADY not 1.
- When TIMEOUT_CYCLES > 0 and the count reaches TIMEOUT_CYCLES, the block SHALL go to RESPONSE with resp_error = 1 and resp_rdata = 0.
- The counter SHALL be ceil(log2(TIMEOUT_CYCLES+1)) bits wide and SHALL NOT wrap.
REQ-013 In RESPONSE, PSEL = PENABLE = 0 and resp_valid = 1, with resp_rdata/resp_error held stable; on resp_ready = 1 at an edge the next state SHALL be IDLE.
REQ-014 Outside SETUP/ACCESS, PADDR/PWRITE/PWDATA SHALL keep their last driven values.
REQ-015 Minimum latency SHALL be:
- request accepted at edge 0;
- SETUP in cycle 1;
- ACCESS in cycle 2;
- resp_valid in cycle 3;
- next req_ready in the cycle after the resp_ready handshake.
- Each wait state SHALL add exactly 1 cycle.

Reset
REQ-016 While PRESET = 1 at a rising edge, the block SHALL enter IDLE and clear all outputs and internal registers to 0, except req_ready, which SHALL be 1 from the first cycle after reset.
REQ-017 Reset asserted in any state SHALL abort the transfer with no response; PSEL/PENABLE SHALL be 0 in the cycle after the reset edge.

Verification
REQ-018 With a zero-wait slave, write 0xDEADBEEF to address 0x3 and then read 0x3.
- Required: PSEL rises in cycle 1 and PENABLE in cycle 2; resp_valid is high in cycle 3.
- Required: the read returns resp_rdata = 0xDEADBEEF, resp_error = 0.
REQ-019 Slave holds PREADY low for 3 ACCESS cycles.
- Required: PENABLE is high for 4 cycles and PADDR/PWRITE/PWDATA are constant throughout.
- Required: resp_valid is high in cycle 6.
REQ-020 TIMEOUT_CYCLES = 16 and PREADY stuck at 0.
- Required: exactly 16 ACCESS cycles, then RESPONSE with resp_error = 1 and resp_rdata = 0, with PSEL low.
REQ-021 Slave returns PREADY = 1, PSLVERR = 1 on a read of 0x5 with PRDATA = 0x12345678.
- Required: resp_error = 1 and resp_rdata = 0x12345678.
REQ-022 Hold resp_ready low for 5 cycles with req_valid held high.
- Required: resp_valid, resp_rdata and resp_error are stable and req_ready stays 0.
- Required: the next transfer starts only after the handshake.
REQ-023 Assert PRESET for 1 cycle during ACCESS.
- Required: next cycle is IDLE with PSEL = PENABLE = resp_valid = 0 and req_ready = 1.
- Required: no response is ever issued for the aborted transfer.

Source files
------------

// File: rtl/apb3_master_if.sv
// Command/response and APB3 bus signals of the APB3 master.
// The master modport is the block's view; slave is the environment's.
interface apb3_master_if #(
  parameter int N_BIT_DATA    = 32,
  parameter int N_BIT_ADDRESS = 4
) ();
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [N_BIT_ADDRESS-1:0] req_address;
  logic [N_BIT_DATA-1:0]    req_wdata;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [N_BIT_DATA-1:0]    resp_rdata;
  logic                     resp_error;
  logic                     PSEL;
  logic                     PENABLE;
  logic                     PWRITE;
  logic [N_BIT_ADDRESS-1:0] PADDR;
  logic [N_BIT_DATA-1:0]    PWDATA;
  logic [N_BIT_DATA-1:0]    PRDATA;
  logic                     PREADY;
  logic                     PSLVERR;

  modport master (
    input  req_valid, req_write, req_address, req_wdata,
    input  resp_ready, PRDATA, PREADY, PSLVERR,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_address, req_wdata,
    output resp_ready, PRDATA, PREADY, PSLVERR,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb3_master.sv
// Single-outstanding APB3 master: command in, one response out.
// Optional ACCESS timeout aborts a hung slave with an error response.
module apb3_master #(
  parameter int N_BIT_DATA     = 32,
  parameter int N_BIT_ADDRESS  = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         PCLK,
  input  logic         PRESET,
  apb3_master_if.master bus
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESPONSE
  } state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [N_BIT_ADDRESS-1:0] addr_q, addr_d;
  logic                     write_q, write_d;
  logic [N_BIT_DATA-1:0]    wdata_q, wdata_d;
  logic [N_BIT_DATA-1:0]    rdata_q, rdata_d;
  logic                     err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid == 1'b1) begin
          addr_d  = bus.req_address;
          write_d = bus.req_write;
          wdata_d = bus.req_wdata;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // X/Z on PREADY falls through to the wait branch
        if (bus.PREADY == 1'b1) begin
          err_d = 1'b0;
          if (bus.PSLVERR == 1'b1) err_d = 1'b1;
          rdata_d = write_q ? '0 : bus.PRDATA;
          state_d = RESPONSE;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (TIMEOUT_CYCLES > 0 &&
              cnt_d == CW'(TIMEOUT_CYCLES)) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESPONSE;
          end
        end
      end
      RESPONSE: begin
        if (bus.resp_ready == 1'b1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.PSEL       = (state_q == SETUP) ||
                          (state_q == ACCESS);
  assign bus.PENABLE    = (state_q == ACCESS);
  assign bus.resp_valid = (state_q == RESPONSE);
  assign bus.PADDR      = addr_q;
  assign bus.PWRITE     = write_q;
  assign bus.PWDATA     = wdata_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = err_q;
endmodule

// File: tb/tb_apb3_master.sv
// Directed bench for apb3_master: latency, wait states,
// timeout, slave error, response backpressure and reset abort.
module tb_apb3_master;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   en_cnt;

  logic [31:0] mem [16];
  logic        rd_ovr;
  logic [31:0] rd_val;

  apb3_master_if #(.N_BIT_DATA(32), .N_BIT_ADDRESS(4)) bus ();

  apb3_master #(
    .N_BIT_DATA(32),
    .N_BIT_ADDRESS(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(clk),
    .PRESET(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // tiny slave memory; writes land on a completed write access
  always @(posedge clk)
    if (bus.PSEL && bus.PENABLE && bus.PWRITE && bus.PREADY)
      mem[bus.PADDR] <= bus.PWDATA;

  assign bus.PRDATA = rd_ovr ? rd_val : mem[bus.PADDR];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(logic w, logic [3:0] a, logic [31:0] d);
    bus.req_valid   = 1'b1;
    bus.req_write   = w;
    bus.req_address = a;
    bus.req_wdata   = d;
  endtask

  task automatic handshake();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_address = '0;
    bus.req_wdata   = '0;
    bus.resp_ready  = 1'b0;
    bus.PREADY      = 1'b0;
    bus.PSLVERR     = 1'b0;
    rd_ovr          = 1'b0;
    rd_val          = '0;
    tick();
    tick();
    chk("rst_psel", bus.PSEL, 0);
    chk("rst_penable", bus.PENABLE, 0);
    chk("rst_rvalid", bus.resp_valid, 0);
    chk("rst_rdy", bus.req_ready, 1);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_pwdata", bus.PWDATA, 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    chk("rst_err", bus.resp_error, 0);
    rst = 1'b0;
    tick();

    // zero-wait write then read of 0x3
    bus.PREADY = 1'b1;
    req(1'b1, 4'h3, 32'hDEAD_BEEF);
    tick();
    bus.req_valid = 1'b0;
    chk("wr_c1_psel", bus.PSEL, 1);
    chk("wr_c1_pen", bus.PENABLE, 0);
    chk("wr_c1_rdy", bus.req_ready, 0);
    chk("wr_c1_paddr", bus.PADDR, 32'h3);
    chk("wr_c1_pwrite", bus.PWRITE, 1);
    chk("wr_c1_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
    tick();
    chk("wr_c2_psel", bus.PSEL, 1);
    chk("wr_c2_pen", bus.PENABLE, 1);
    tick();
    chk("wr_c3_rvalid", bus.resp_valid, 1);
    chk("wr_c3_psel", bus.PSEL, 0);
    chk("wr_c3_rdata", bus.resp_rdata, 0);
    chk("wr_c3_err", bus.resp_error, 0);
    handshake();
    chk("wr_idle_rdy", bus.req_ready, 1);
    chk("wr_idle_rvalid", bus.resp_valid, 0);
    chk("wr_idle_paddr", bus.PADDR, 32'h3);

    req(1'b0, 4'h3, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    chk("rd_c1_psel", bus.PSEL, 1);
    chk("rd_c1_pwrite", bus.PWRITE, 0);
    tick();
    chk("rd_c2_pen", bus.PENABLE, 1);
    tick();
    chk("rd_c3_rvalid", bus.resp_valid, 1);
    chk("rd_c3_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
    chk("rd_c3_err", bus.resp_error, 0);
    handshake();

    // three wait states
    bus.PREADY = 1'b0;
    req(1'b1, 4'h7, 32'hA5A5_0001);
    tick();
    bus.req_valid = 1'b0;
    tick();
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.PREADY = 1'b1;
      if (bus.PENABLE) en_cnt++;
      chk("ws_paddr", bus.PADDR, 32'h7);
      chk("ws_pwrite", bus.PWRITE, 1);
      chk("ws_pwdata", bus.PWDATA, 32'hA5A5_0001);
      chk("ws_rvalid", bus.resp_valid, 0);
      tick();
    end
    chk("ws_en_cycles", en_cnt, 4);
    chk("ws_c6_rvalid", bus.resp_valid, 1);
    chk("ws_c6_pen", bus.PENABLE, 0);
    bus.PREADY = 1'b0;
    handshake();

    // PREADY stuck low: timeout after 16 ACCESS cycles
    req(1'b0, 4'h9, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    en_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.PENABLE) en_cnt++;
      chk("to_rvalid_low", bus.resp_valid, 0);
      tick();
    end
    chk("to_access_cycles", en_cnt, 16);
    chk("to_rvalid", bus.resp_valid, 1);
    chk("to_psel", bus.PSEL, 0);
    chk("to_err", bus.resp_error, 1);
    chk("to_rdata", bus.resp_rdata, 0);
    handshake();

    // slave error on read of 0x5
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b1;
    rd_ovr      = 1'b1;
    rd_val      = 32'h1234_5678;
    req(1'b0, 4'h5, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    bus.PSLVERR = 1'b0;
    rd_ovr      = 1'b0;
    chk("se_rvalid", bus.resp_valid, 1);
    chk("se_err", bus.resp_error, 1);
    chk("se_rdata", bus.resp_rdata, 32'h1234_5678);

    // response backpressure with a pending request
    req(1'b1, 4'h2, 32'h0000_1111);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid", bus.resp_valid, 1);
      chk("bp_rdata", bus.resp_rdata, 32'h1234_5678);
      chk("bp_err", bus.resp_error, 1);
      chk("bp_rdy", bus.req_ready, 0);
      chk("bp_psel", bus.PSEL, 0);
      tick();
    end
    handshake();
    chk("bp_idle_rdy", bus.req_ready, 1);
    chk("bp_idle_psel", bus.PSEL, 0);
    tick();
    bus.req_valid = 1'b0;
    chk("bp_next_psel", bus.PSEL, 1);
    chk("bp_next_paddr", bus.PADDR, 32'h2);
    chk("bp_next_pwdata", bus.PWDATA, 32'h0000_1111);
    tick();
    tick();
    chk("bp_next_rvalid", bus.resp_valid, 1);
    chk("bp_next_err", bus.resp_error, 0);
    handshake();

    // reset during ACCESS aborts silently
    bus.PREADY = 1'b0;
    req(1'b0, 4'h4, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("ra_in_access", bus.PENABLE, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ra_psel", bus.PSEL, 0);
    chk("ra_pen", bus.PENABLE, 0);
    chk("ra_rvalid", bus.resp_valid, 0);
    chk("ra_rdy", bus.req_ready, 1);
    bus.PREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ra_no_resp", bus.resp_valid, 0);
      chk("ra_no_psel", bus.PSEL, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
